// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the data memory controller.
// master drives requests, slave (the controller) returns responses.
interface data_memory_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    input  ready_o, valid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    output ready_o, valid_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with fixed-latency single-outstanding access.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned accesses error out instead of being force-aligned.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  data_memory_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            we_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [7:0]      mem [DEPTH_BYTES];

  logic [AW-1:0]   base_c, a1_c, a2_c, a3_c;
  logic [7:0]      b0_c, b1_c, b2_c, b3_c;
  logic [31:0]     load_c;
  logic            misalign_c;
  logic            err_c;
  logic            commit_c;

  // Effective byte address: checked or force-aligned depending on build
`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    base_c     = addr_q;
    misalign_c = ((size_q == 2'b01) && addr_q[0]) ||
                 ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  end
`else
  always_comb begin
    misalign_c = 1'b0;
    case (size_q)
      2'b01:   base_c = {addr_q[AW-1:1], 1'b0};
      2'b10:   base_c = {addr_q[AW-1:2], 2'b00};
      default: base_c = addr_q;
    endcase
  end
`endif

  assign a1_c = base_c + AW'(1);
  assign a2_c = base_c + AW'(2);
  assign a3_c = base_c + AW'(3);

  assign b0_c = mem[base_c];
  assign b1_c = mem[a1_c];
  assign b2_c = mem[a2_c];
  assign b3_c = mem[a3_c];

  assign err_c    = (size_q == 2'b11) || misalign_c;
  assign commit_c = (state_q == WAIT) && (cnt_q == '0);

  always_comb begin
    case (size_q)
      2'b00:   load_c = {{24{b0_c[7] & ~uns_q}}, b0_c};
      2'b01:   load_c = {{16{b1_c[7] & ~uns_q}}, b1_c, b0_c};
      default: load_c = {b3_c, b2_c, b1_c, b0_c};
    endcase
  end

  // Next state, latency counter and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = commit_c;
    err_d   = commit_c && err_c;
    rdata_d = (commit_c && !we_q && !err_c) ? load_c : 32'h0;
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields are captured only on acceptance and held through the access
  always_ff @(posedge clk_i) begin
    if ((state_q == IDLE) && bus.req_i) begin
      we_q    <= bus.we_i;
      uns_q   <= bus.unsigned_i;
      size_q  <= bus.size_i;
      addr_q  <= bus.addr_i[AW-1:0];
      wdata_q <= bus.wdata_i;
    end
  end

  // Memory is never reset; a reset at the commit edge cancels the store
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit_c && we_q && !err_c) begin
      mem[base_c] <= wdata_q[7:0];
      if (size_q != 2'b00) mem[a1_c] <= wdata_q[15:8];
      if (size_q == 2'b10) begin
        mem[a2_c] <= wdata_q[23:16];
        mem[a3_c] <= wdata_q[31:24];
      end
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: byte-array reference model, directed cases and random traffic.
module tb_data_memory_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_ctrl_if bus();

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mm [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic        end_req = 1'b0;
  logic        mon_done = 1'b0;
  logic        rdy_pend = 1'b0;
  int          rst_seq = 0;
  int          rst_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: memory is a plain byte array, accesses are arithmetic on byte offsets
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd);
    int     n;
    int     base;
    longint v;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = int'(addr % DEPTH);
    err  = (size == 2'd3);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)) err = 1'b1;
`else
    base = base - base % n;
`endif
    rd = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mm[(base + i) % DEPTH] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(mm[(base + i) % DEPTH]) << (8 * i);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      rd = 32'(v);
    end
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Monitor: pops an expectation for every valid pulse, checks quiet outputs otherwise
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (rst_seen != rst_seq) begin
        chk("reset_ready", 32'(bus.ready_o), 32'd1);
        chk("reset_valid", 32'(bus.valid_o), 32'd0);
        rst_seen = rst_seq;
      end
      if (rdy_pend) begin
        chk("ready_after_valid", 32'(bus.ready_o), 32'd1);
        rdy_pend = 1'b0;
      end
      if (bus.valid_o) begin
        chk("ready_low_in_resp", 32'(bus.ready_o), 32'd0);
        chk("expected_response", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
          chk("err", 32'(bus.err_o), 32'(e.err));
          chk("rdata", bus.rdata_o, e.rd);
        end
        rdy_pend = 1'b1;
      end else begin
        chk("quiet_rdata", bus.rdata_o, 32'h0);
        chk("quiet_err", 32'(bus.err_o), 32'd0);
      end
      if (end_req && !mon_done) begin
        chk("queue_drained", 32'(sb.size()), 32'd0);
        mon_done = 1'b1;
      end
    end
  end

  // Issue one request; use_c substitutes a fixed expectation, abort resets mid-access
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input logic use_c, input logic err_c, input logic [31:0] rd_c,
                        input logic abort);
    exp_t        e;
    logic        me;
    logic [31:0] mr;
    int          n;
    n = 0;
    @(negedge clk);
    while (!bus.ready_o) begin
      n++;
      if (n > 50) begin
        $display("FAIL ready_timeout: got 0 want 1 (cycle %0d)", cyc);
        $fatal(1, "ready never returned");
      end
      @(negedge clk);
    end
    bus.req_i      = 1'b1;
    bus.we_i       = we;
    bus.size_i     = size;
    bus.unsigned_i = uns;
    bus.addr_i     = addr;
    bus.wdata_i    = wdata;
    if (!abort) begin
      model(we, size, uns, addr, wdata, me, mr);
      e.cyc = cyc + 1 + int'(LAT);
      e.err = use_c ? err_c : me;
      e.rd  = use_c ? rd_c : mr;
      sb.push_back(e);
    end
    @(negedge clk);
    if (abort) begin
      bus.req_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rst_seq++;
    end else begin
      for (int i = 0; i < hold; i++) begin
        bus.we_i    = 1'($urandom);
        bus.size_i  = 2'($urandom);
        bus.addr_i  = $urandom;
        bus.wdata_i = $urandom;
        @(negedge clk);
      end
      bus.req_i = 1'b0;
    end
  endtask

  initial begin : drv
    logic [31:0] a;
    logic [31:0] exp39;
    logic        err39;
    bus.req_i      = 1'b0;
    bus.we_i       = 1'b0;
    bus.size_i     = 2'b00;
    bus.unsigned_i = 1'b0;
    bus.addr_i     = 32'h0;
    bus.wdata_i    = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    rst_seq++;

    for (int i = 0; i < int'(DEPTH); i += 4)
      do_req(1'b1, 2'b10, 1'b0, 32'(i), $urandom, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    do_req(1'b1, 2'b10, 1'b0, 32'h10,  32'h8899AABC, 0, 1'b1, 1'b0, 32'h0,        1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        0, 1'b1, 1'b0, 32'h000000AA, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        0, 1'b1, 1'b0, 32'hFFFFAABC, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        0, 1'b1, 1'b0, 32'h0000AABC, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h410, 32'h0000005A, 0, 1'b1, 1'b0, 32'h0,        1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        2, 1'b1, 1'b0, 32'h8899AA5A, 1'b0);

    do_req(1'b1, 2'b10, 1'b0, 32'h20,  32'h11223344, 0, 1'b1, 1'b0, 32'h0,        1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'h20,  32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0,        1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        0, 1'b1, 1'b0, 32'h11223344, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    err39 = 1'b1; exp39 = 32'h0;
`else
    err39 = 1'b0; exp39 = 32'h8899AA5A;
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'h13,  32'h0,        1, 1'b1, err39, exp39,      1'b0);
    do_req(1'b1, 2'b11, 1'b0, 32'h10,  32'hFFFFFFFF, 0, 1'b1, 1'b1, 32'h0,        1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        0, 1'b1, 1'b0, 32'h8899AA5A, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else                           a = $urandom & 32'h0000_0FFF;
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
             int'($urandom_range(0, LAT)), 1'b0, 1'b0, 32'h0, 1'b0);
    end

    repeat (LAT + 3) @(negedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_done: got 0 want 1");
      $fatal(1, "monitor did not complete");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, 1024, memory size in bytes; power of two, minimum 4.
REQ-002 SHALL have parameter LATENCY, 1, number of cycles from request acceptance to response; minimum 1, maximum 15.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_i  input  1  request strobe.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port size_i  input  2  access size: 00 = byte, 01 = half, 10 = word; 11 is reserved.
REQ-008 SHALL have port unsigned_i  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-009 SHALL have port addr_i  input  32  byte address.
REQ-010 SHALL have port wdata_i  input  32  store data; the low bytes are used according to size.
REQ-011 SHALL have port ready_o  output  1  controller is idle and can accept a request.
REQ-012 SHALL have port valid_o  output  1  one-cycle response pulse.
REQ-013 SHALL have port rdata_o  output  32  load result.
REQ-014 SHALL have port err_o  output  1  the access was rejected; qualified by valid_o.

Function
REQ-015 SHALL store data as a byte array of DEPTH_BYTES entries in little-endian order: byte addr holds bits [7:0] and byte addr+1 holds bits [15:8].
REQ-016 SHALL index memory with addr_i modulo DEPTH_BYTES, so upper address bits are ignored and accesses wrap.
REQ-017 SHALL implement a state machine with states IDLE, WAIT and RESP.
REQ-018 In IDLE, SHALL drive ready_o=1 and SHALL accept a request on a rising edge where req_i=1, latching addr_i, we_i, size_i, unsigned_i and wdata_i.
REQ-019 SHALL ignore req_i in WAIT and RESP; requests made in those states are dropped, not queued.
REQ-020 On acceptance, SHALL load a down-counter with LATENCY-1 and move to WAIT; a counter value of 0 in WAIT moves the machine to RESP on the next edge.
REQ-021 Timing: for a request accepted at edge k, SHALL hold valid_o=1 for exactly one cycle, from edge k+LATENCY to edge k+LATENCY+1, then return to IDLE; ready_o=0 during WAIT and RESP.
REQ-022 SHALL commit a store at edge k+LATENCY and write only 1, 2 or 4 bytes as selected by size.
REQ-023 SHALL make a load sample memory at edge k+LATENCY; a store committed at an earlier edge is visible to the load.
REQ-024 SHALL sign-extend or zero-extend byte and half loads to 32 bits per unsigned_i.
REQ-025 SHALL drive rdata_o=0 whenever valid_o=0, and for every store response.
REQ-026 SHALL treat size_i=11 as an error: err_o=1 with valid_o, no write, and rdata_o=0.
REQ-027 SHALL drive err_o=0 whenever valid_o=0.

Reset
REQ-028 While rst_i=1 at a rising edge, SHALL go to IDLE with counter=0, valid_o=0, err_o=0 and rdata_o=0; ready_o=1 from the first cycle after reset.
REQ-029 A reset during WAIT or RESP SHALL abort the access, and a store whose commit edge has not yet occurred SHALL NOT be written.
REQ-030 Reset SHALL NOT clear memory contents.

Configuration
REQ-031 Macro DMEM_ALIGN_CHECK_EN defined: an access is misaligned when it is a half access with addr[0]=1, or a word access with addr[1:0]≠00.
REQ-032 With DMEM_ALIGN_CHECK_EN defined, a misaligned access SHALL respond at the normal latency with err_o=1, no write, and rdata_o=0.
REQ-033 Macro DMEM_ALIGN_CHECK_EN undefined: the low address bits SHALL be forced to an aligned address (half: addr[0]=0, word: addr[1:0]=00), and err_o is asserted only for size_i=11.

Verification (LATENCY=2, DEPTH_BYTES=1024)
REQ-034 Store a word 0x8899AABC to 0x10, then load it as an unsigned byte from 0x11 -> valid_o 2 cycles after each acceptance; rdata_o=0x000000AA.
REQ-035 Load 0x10 as a signed half -> rdata_o=0xFFFFAABC; load it as an unsigned half -> rdata_o=0x0000AABC.
REQ-036 Store a byte 0x5A to 0x410 (wraps to 0x010), then load the word at 0x10 -> rdata_o=0x8899AA5A.
REQ-037 Pulse req_i during WAIT -> the request is ignored, exactly one valid_o pulse occurs, and ready_o returns to 1 the cycle after valid_o.
REQ-038 Assert rst_i one cycle after a store to 0x20 is accepted, then load the word at 0x20 -> the old contents are returned and valid_o does not pulse for the aborted store.
REQ-039 With DMEM_ALIGN_CHECK_EN defined, load a word from 0x13 -> err_o=1 and rdata_o=0; with it undefined, the same load returns the word at 0x10.
